// File: rtl/ccff_chain_loader.sv
// Serial configuration-chain loader: host words shifted MSB first into ccff_head,
// with optional readback of ccff_tail (enabled by defining CCFF_READBACK_EN).
module ccff_chain_loader #(
    parameter int WORD_W = 32,
    parameter int LEN_W  = 20
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  chain_len,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_clk_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    localparam logic [LEN_W-1:0] WORD_L = LEN_W'(WORD_W);
    localparam logic [LEN_W-1:0] ONE_L  = LEN_W'(1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [LEN_W-1:0]   wordbits_q, wordbits_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic               clk_en_q, busy_q, done_q;
    logic               stall, shift, last_bit;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        wordbits_d  = wordbits_q;
        shreg_d     = shreg_q;
        shift       = 1'b0;
        last_bit    = (remaining_q == ONE_L);
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (chain_len != '0) begin
                        remaining_d = chain_len;
                        state_d     = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                if (wr_valid && !stall) begin
                    shreg_d    = wr_data;
                    wordbits_d = (remaining_q < WORD_L) ? remaining_q : WORD_L;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (!stall) begin
                    shift       = 1'b1;
                    shreg_d     = {shreg_q[WORD_W-2:0], 1'b0};
                    remaining_d = remaining_q - ONE_L;
                    wordbits_d  = wordbits_q - ONE_L;
                    if (last_bit)
                        state_d = DONE;
                    else if (wordbits_q == ONE_L)
                        state_d = FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Readback words only complete at word ends, so rd_valid is always clear
    // throughout SHIFT; the enable can therefore be registered from state_d.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            wordbits_q  <= '0;
            shreg_q     <= '0;
            clk_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wordbits_q  <= wordbits_d;
            shreg_q     <= shreg_d;
            clk_en_q    <= (state_d == SHIFT);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    assign wr_ready    = (state_q == FETCH) & ~stall;
    assign ccff_head   = shreg_q[WORD_W-1];
    assign ccff_clk_en = clk_en_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef CCFF_READBACK_EN
    localparam int CW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] rbreg_q, rbreg_d, rd_data_q, rd_data_d;
    logic [CW-1:0]     rbcnt_q, rbcnt_d;
    logic              rd_valid_q, rd_valid_d;

    assign stall = rd_valid_q & ~rd_ready;

    always_comb begin
        rbreg_d    = rbreg_q;
        rbcnt_d    = rbcnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q & ~rd_ready;
        if (shift) begin
            rbreg_d = {rbreg_q[WORD_W-2:0], ccff_tail};
            rbcnt_d = rbcnt_q + CW'(1);
            if (rbcnt_d == CW'(WORD_W) || last_bit) begin
                rd_data_d  = rbreg_d;
                rd_valid_d = 1'b1;
                rbreg_d    = '0;
                rbcnt_d    = '0;
            end
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            rbreg_q    <= '0;
            rbcnt_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rbreg_q    <= rbreg_d;
            rbcnt_q    <= rbcnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`else
    logic unused_rb;
    assign unused_rb = ^{rd_ready, ccff_tail, shift};
    assign stall     = 1'b0;
    assign rd_data   = '0;
    assign rd_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a behavioural 64-bit chain model on ccff_head/ccff_tail.
module tb_ccff_chain_loader;
    localparam int W  = 32;
    localparam int LW = 20;
`ifdef CCFF_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic          prog_clk = 1'b0;
    logic          prog_reset_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] chain_len = '0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          rd_ready = 1'b0;
    logic          wr_ready, ccff_head, ccff_tail, ccff_clk_en, rd_valid, busy, done;
    logic [W-1:0]  rd_data;

    int n_chk = 0;
    int n_fail = 0;

    logic [63:0] chain;
    logic [63:0] pre_val = '0;
    logic        pre_load = 1'b1;
    logic [6:0]  mlen = 7'd64;

    ccff_chain_loader #(.WORD_W(W), .LEN_W(LW)) dut (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start),
        .chain_len(chain_len), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
        .ccff_clk_en(ccff_clk_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .busy(busy), .done(done)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: the gated edge samples ccff_head; tail is the last of mlen tiles.
    always @(posedge prog_clk) begin
        if (pre_load)
            chain <= pre_val;
        else if (ccff_clk_en)
            chain <= {chain[62:0], ccff_head};
    end
    assign ccff_tail = chain[mlen - 7'd1];

    typedef struct {
        logic [LW-1:0] len;
        logic [W-1:0]  w0, w1;
        logic [63:0]   pre, exp_chain;
        logic [W-1:0]  rd0, rd1;
        int            nrd;
        int            ncyc;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_head"},  ccff_head,   0);
        chk({tag, "_en"},    ccff_clk_en, 0);
        chk({tag, "_wrrdy"}, wr_ready,    0);
        chk({tag, "_rdv"},   rd_valid,    0);
        chk({tag, "_rdd"},   rd_data,     0);
        chk({tag, "_busy"},  busy,        0);
        chk({tag, "_done"},  done,        0);
    endtask

    task automatic run_vec(input vec_t v, input int hold, input string tag);
        logic [W-1:0] rq[$];
        int en_cnt = 0, done_cyc = -1, ndone = 0, rv_cyc = -1, wdx = 0, h = hold;
        logic hs = 1'b0, head_s = 1'b0;
        logic [63:0] mask;
        @(negedge prog_clk);
        pre_val = v.pre; pre_load = 1'b1; mlen = v.len[6:0];
        @(negedge prog_clk);
        pre_load = 1'b0; chain_len = v.len; start = 1'b1;
        wr_valid = 1'b1; wr_data = v.w0; rd_ready = (h == 0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge prog_clk);
            if (cyc == 0) begin
                start = 1'b0;
                chk({tag, "_busy_rise"}, busy, 1);
            end
            if (hs) begin
                wdx++;
                wr_data = (wdx == 1) ? v.w1 : '0;
            end
            if (h == 0) rd_ready = 1'b1;
            if (rd_valid && !rd_ready) begin
                if (h == hold) head_s = ccff_head;
                chk({tag, "_stall_en"},   ccff_clk_en, 0);
                chk({tag, "_stall_wr"},   wr_ready,    0);
                chk({tag, "_stall_head"}, ccff_head,   head_s);
                h--;
            end
            if (ccff_clk_en) en_cnt++;
            if (rd_valid && rv_cyc < 0) rv_cyc = cyc;
            if (rd_valid && rd_ready) rq.push_back(rd_data);
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            hs = wr_valid & wr_ready;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        wr_valid = 1'b0;
        mask = (v.len >= 64) ? '1 : ((64'd1 << v.len) - 64'd1);
        chk({tag, "_done_cyc"}, done_cyc, v.ncyc + (RB ? hold : 0));
        chk({tag, "_done_cnt"}, ndone, 1);
        chk({tag, "_en_cnt"},   en_cnt, v.len);
        chk({tag, "_chain"},    chain & mask, v.exp_chain);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_rv_cyc"},   rv_cyc, RB ? 33 : -1);
        chk({tag, "_nrd"},      rq.size(), RB ? v.nrd : 0);
        if (rq.size() >= 1) chk({tag, "_rd0"}, rq[0], v.rd0);
        if (rq.size() >= 2) chk({tag, "_rd1"}, rq[1], v.rd1);
    endtask

    initial begin
        vec_t tv[3];
        tv[0] = '{len: 64, w0: 32'hA5A5_0001, w1: 32'h8000_00FF,
                  pre: 64'h0123_4567_89AB_CDEF, exp_chain: 64'hA5A5_0001_8000_00FF,
                  rd0: 32'h0123_4567, rd1: 32'h89AB_CDEF, nrd: 2, ncyc: 66};
        tv[1] = '{len: 40, w0: 32'hDEAD_BEEF, w1: 32'hFF00_0000,
                  pre: 64'h0000_00A1_B2C3_D4E5, exp_chain: 64'h0000_00DE_ADBE_EFFF,
                  rd0: 32'hA1B2_C3D4, rd1: 32'h0000_00E5, nrd: 2, ncyc: 42};
        tv[2] = '{len: 32, w0: 32'hCAFE_F00D, w1: 32'h0,
                  pre: 64'h0000_0000_1234_5678, exp_chain: 64'h0000_0000_CAFE_F00D,
                  rd0: 32'h1234_5678, rd1: 32'h0, nrd: 1, ncyc: 33};

        repeat (3) @(negedge prog_clk);
        chk_zero("reset");
        prog_reset_n = 1'b1;
        pre_load = 1'b0;

        for (int i = 0; i < 3; i++) run_vec(tv[i], 0, $sformatf("vec%0d", i));

        run_vec(tv[0], 5, "stall");

        // Zero-length load: straight to DONE, no word consumed; start in DONE ignored.
        @(negedge prog_clk);
        chain_len = '0; start = 1'b1; wr_valid = 1'b1; wr_data = 32'h1111_1111;
        @(negedge prog_clk);
        chain_len = 20'd8;
        chk("zero_done", done, 1);
        chk("zero_wrrdy", wr_ready, 0);
        chk("zero_busy", busy, 1);
        @(negedge prog_clk);
        start = 1'b0;
        chk("zero_done_fall", done, 0);
        chk("zero_idle", busy, 0);
        chk("zero_wrrdy2", wr_ready, 0);
        @(negedge prog_clk);
        chk("zero_start_in_done_ignored", busy, 0);
        wr_valid = 1'b0;

        // Mid-load disturbances: starved FETCH, start during SHIFT, reset mid-word.
        @(negedge prog_clk);
        pre_val = '0; pre_load = 1'b1; mlen = 7'd64;
        @(negedge prog_clk);
        pre_load = 1'b0; chain_len = 20'd64; start = 1'b1;
        wr_valid = 1'b1; wr_data = 32'hA5A5_0001; rd_ready = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        @(negedge prog_clk);
        wr_valid = 1'b0; wr_data = '0; start = 1'b1; chain_len = '0;
        @(negedge prog_clk);
        start = 1'b0;
        chk("mid_start_ignored_en", ccff_clk_en, 1);
        chk("mid_start_ignored_busy", busy, 1);
        repeat (31) @(negedge prog_clk);
        chk("mid_fetch_wrrdy", wr_ready, 1);
        chk("mid_fetch_en", ccff_clk_en, 0);
        repeat (3) @(negedge prog_clk);
        chk("mid_starve_wrrdy", wr_ready, 1);
        chk("mid_starve_en", ccff_clk_en, 0);
        chk("mid_starve_busy", busy, 1);
        wr_valid = 1'b1; wr_data = 32'h8000_00FF;
        @(negedge prog_clk);
        wr_valid = 1'b0;
        chk("mid_resume_en", ccff_clk_en, 1);
        repeat (4) @(negedge prog_clk);
        prog_reset_n = 1'b0;
        @(negedge prog_clk);
        chk_zero("midrst");
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
        chk("midrst_idle", busy, 0);

        run_vec(tv[1], 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
